// File: rtl/rr_decode_arbiter_if.sv
// Bundle of the signals between the requesters and rr_decode_arbiter.
//   req          [7:0]  request vector, bit i = requester i wants the bus
//   release_req         current owner gives up its grant this cycle
//                       ("release" is a reserved word in SystemVerilog)
//   sel          [2:0]  registered index of the granted requester (decoder A)
//   en                  registered grant-valid (decoder EN)
//   gnt          [7:0]  one-hot grant, gnt[sel] = en, all zero when en = 0
//   busy                high while a grant is active (equals en)
//   timeout             one-cycle pulse after a grant ended by hold expiry
// The master modport is the requester side; the slave modport is the arbiter.
interface rr_decode_arbiter_if;
  logic [7:0] req;
  logic       release_req;
  logic [2:0] sel;
  logic       en;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output release_req,
    input  sel,
    input  en,
    input  gnt,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  release_req,
    output sel,
    output en,
    output gnt,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 enabled decoder among 8 requesters.
// The decoder select and enable come straight from flops; gnt is the decoded
// one-hot view of them. Each grant is bounded to MAX_HOLD cycles and is always
// followed by at least one idle cycle with en = 0, so two owners never overlap.
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   rr_decode_arbiter_if.slave (req, release_req in; sel, en, gnt, busy,
//         timeout out)
// MAX_HOLD must be in 1..255 and CNT_W must satisfy 2**CNT_W > MAX_HOLD.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_decode_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  state_e             state_q;
  logic [2:0]         sel_q;
  logic               en_q;
  logic               timeout_q;
  logic [2:0]         ptr_q;       // index of the last granted requester
  logic [CNT_W-1:0]   hold_cnt_q;  // grant cycles elapsed, minus one

  // Round-robin search starting just after ptr_q, wrapping modulo 8.
  logic       win_found;
  logic [2:0] win_idx;

  always_comb begin
    logic [2:0] idx;
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i + 1);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Exit conditions while granting.
  logic owner_drop;
  logic hold_expire;
  logic grant_exit;

  always_comb begin
    owner_drop  = ~bus.req[sel_q];
    hold_expire = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    grant_exit  = owner_drop | bus.release_req | hold_expire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= 3'd0;
      en_q       <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= 3'd7;
      hold_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timeout_q <= 1'b0;
          if (win_found) begin
            sel_q      <= win_idx;
            en_q       <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          if (grant_exit) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            ptr_q     <= sel_q;
            // Only a pure expiry is flagged; a voluntary end wins over it.
            timeout_q <= hold_expire & ~owner_drop & ~bus.release_req;
          end else if (hold_cnt_q != CNT_W'(MAX_HOLD)) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.en      = en_q;
  assign bus.busy    = en_q;
  assign bus.timeout = timeout_q;
  assign bus.gnt     = en_q ? (8'b1 << sel_q) : 8'b0;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter with MAX_HOLD = 15.
module tb_rr_decode_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rr_decode_arbiter_if bus ();

  rr_decode_arbiter #(
    .MAX_HOLD (15),
    .CNT_W    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_to);
    chk({tag, ".en"}, 32'(bus.en), 32'd0);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'h00);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'(exp_to));
  endtask

  task automatic chk_grant(input string tag, input int s);
    logic [7:0] oh;
    oh = 8'h01 << s;
    chk({tag, ".en"}, 32'(bus.en), 32'd1);
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(oh));
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = 8'h00;
    bus.release_req = 1'b0;

    // Reset values, both before and across a clock edge.
    #2;
    chk_idle("rst_async", 1'b0);
    chk("rst_async.sel", 32'(bus.sel), 32'd0);
    tick();
    chk_idle("rst_edge", 1'b0);
    #6;
    rst = 1'b0;

    // No requests: stays idle.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("noreq", 1'b0);
      chk("noreq.sel", 32'(bus.sel), 32'd0);
    end

    // Single requester 0, release during grant cycle 3.
    bus.req = 8'h01;
    tick();
    chk_grant("r0_c1", 0);
    tick();
    chk_grant("r0_c2", 0);
    tick();
    chk_grant("r0_c3", 0);
    bus.release_req = 1'b1;
    tick();
    chk_idle("r0_rel", 1'b0);
    bus.release_req = 1'b0;
    tick();
    chk_grant("r0_regrant", 0);
    bus.req = 8'h00;
    tick();
    chk_idle("r0_drop", 1'b0);

    // Reset pulse between edges restores ptr = 7; then full rotation.
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    bus.req = 8'hFF;
    bus.release_req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_grant($sformatf("rot%0d", k), k % 8);
      tick();
      chk_idle($sformatf("rot%0d_gap", k), 1'b0);
    end
    bus.req = 8'h00;
    bus.release_req = 1'b0;
    tick();
    chk_idle("rot_end", 1'b0);

    // Hold expiry: 15 grant cycles, timeout pulse, re-grant.
    bus.req = 8'h10;
    tick();
    chk_grant("hold_c1", 4);
    for (int c = 2; c <= 15; c++) begin
      tick();
      chk_grant($sformatf("hold_c%0d", c), 4);
    end
    tick();
    chk_idle("hold_to", 1'b1);
    tick();
    chk_grant("hold_regrant", 4);
    bus.req = 8'h00;
    tick();
    chk_idle("hold_drop", 1'b0);

    // Owner 5 drops its request; search continues 6,7,0 then 1,2,3.
    bus.req = 8'h20;
    tick();
    chk_grant("drop_g5", 5);
    bus.req = 8'h09;
    tick();
    chk_idle("drop_exit", 1'b0);
    tick();
    chk_grant("drop_g0", 0);
    bus.release_req = 1'b1;
    tick();
    chk_idle("drop_rel0", 1'b0);
    bus.release_req = 1'b0;
    tick();
    chk_grant("drop_g3", 3);
    bus.req = 8'h00;
    tick();
    chk_idle("drop_end", 1'b0);

    // Reset asserted mid-grant drops en/gnt immediately.
    bus.req = 8'h40;
    tick();
    chk_grant("mid_g6", 6);
    #3 rst = 1'b1;
    #1;
    chk_idle("mid_rst", 1'b0);
    chk("mid_rst.sel", 32'(bus.sel), 32'd0);
    bus.req = 8'hC0;
    tick();
    chk_idle("mid_rst_edge", 1'b0);
    #3 rst = 1'b0;
    tick();
    chk_grant("post_rst_g6", 6);

    // Release coinciding with expiry: ends grant with no timeout.
    for (int c = 2; c <= 15; c++) tick();
    chk_grant("exp_rel_c15", 6);
    bus.release_req = 1'b1;
    tick();
    chk_idle("exp_rel", 1'b0);
    bus.release_req = 1'b0;
    tick();
    chk_grant("exp_rel_g7", 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
